// File: rtl/aes_pipe_sched.sv
// aes_pipe_sched: round-robin scheduler sharing a pipelined AES key-round core, with credit-limited output FIFO.
// Optional per-requester issue and credit-stall counters under AES_SCHED_STATS_EN.
module aes_pipe_sched #(
  parameter int NREQ = 4,
  parameter int LATENCY = 50,
  parameter int FIFO_DEPTH = 64,
  parameter int TAGW = $clog2(NREQ),
  localparam int IW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [128*NREQ-1:0]    req_key,
  output logic [NREQ-1:0]        req_ready,
  output logic [127:0]           core_key,
  input  logic [127:0]           core_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [127:0]           out_data,
  output logic [TAGW-1:0]        out_tag,
  output logic [IW-1:0]          inflight
`ifdef AES_SCHED_STATS_EN
  ,
  output logic [NREQ*32-1:0]     stat_issued,
  output logic [31:0]            stat_stall
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int XW = AW > 0 ? AW : 1;
  localparam int PW = AW + 1;
  logic [TAGW-1:0] ptr, gnt;
  logic any, credit_ok, xfer, push, pop, full, empty;
  logic [LATENCY:0] sv;
  logic [TAGW-1:0] st [LATENCY+1];
  logic [127:0] dmem [FIFO_DEPTH];
  logic [TAGW-1:0] tmem [FIFO_DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [XW-1:0] wa, ra;
  // Second loop overrides the first, so requesters at or above ptr win over wrapped ones.
  always_comb begin
    any = 1'b0;
    gnt = '0;
    for (int j = NREQ - 1; j >= 0; j--)
      if (req_valid[j] && TAGW'(j) < ptr) begin
        any = 1'b1;
        gnt = TAGW'(j);
      end
    for (int j = NREQ - 1; j >= 0; j--)
      if (req_valid[j] && TAGW'(j) >= ptr) begin
        any = 1'b1;
        gnt = TAGW'(j);
      end
  end
  assign credit_ok = inflight < IW'(FIFO_DEPTH);
  assign xfer = any & credit_ok & ~rst;
  assign req_ready = xfer ? NREQ'(1) << gnt : '0;
  assign push = sv[LATENCY];
  assign empty = wptr == rptr;
  assign full = (wptr - rptr) == PW'(FIFO_DEPTH);
  assign pop = out_valid & out_ready;
  assign wa = XW'(wptr) & XW'(FIFO_DEPTH - 1);
  assign ra = XW'(rptr) & XW'(FIFO_DEPTH - 1);
  assign out_valid = ~empty;
  assign out_data = empty ? '0 : dmem[ra];
  assign out_tag = empty ? '0 : tmem[ra];
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      core_key <= '0;
      sv <= '0;
      wptr <= '0;
      rptr <= '0;
      inflight <= '0;
    end else begin
      if (xfer) begin
        ptr <= (gnt == TAGW'(NREQ - 1)) ? '0 : gnt + TAGW'(1);
        core_key <= req_key[{gnt, 7'd0} +: 128];
      end
      sv <= {sv[LATENCY-1:0], xfer};
      if (push) wptr <= wptr + PW'(1);
      if (pop) rptr <= rptr + PW'(1);
      inflight <= inflight + IW'(xfer) - IW'(pop);
    end
  end
  // Tags and FIFO storage need no reset: validity lives in sv and the FIFO pointers.
  always_ff @(posedge clk) begin
    st[0] <= gnt;
    for (int i = 1; i <= LATENCY; i++) st[i] <= st[i-1];
    if (push) begin
      dmem[wa] <= core_out;
      tmem[wa] <= st[LATENCY];
    end
  end
  assert property (@(posedge clk) disable iff (rst) !(push && full));
`ifdef AES_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_issued <= '0;
      stat_stall <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++)
        if (req_valid[i] & req_ready[i]) stat_issued[32*i +: 32] <= stat_issued[32*i +: 32] + 32'd1;
      if (|req_valid && !credit_ok) stat_stall <= stat_stall + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_aes_pipe_sched.sv
// tb_aes_pipe_sched: randomized scoreboard bench for aes_pipe_sched with a stand-in pipelined core.
module tb_aes_pipe_sched;
  localparam int NREQ = 4, LATENCY = 50, DEPTH = 64, TAGW = 2, IW = 7;
  logic clk = 0, rst = 1;
  logic [NREQ-1:0] req_valid = '0, req_ready;
  logic [128*NREQ-1:0] req_key = '0;
  logic [127:0] core_key, core_out, out_data;
  logic out_valid, out_ready = 0;
  logic [TAGW-1:0] out_tag;
  logic [IW-1:0] inflight;
`ifdef AES_SCHED_STATS_EN
  logic [NREQ*32-1:0] stat_issued;
  logic [31:0] stat_stall;
  int m_iss [NREQ];
  int m_stall = 0;
`endif
  aes_pipe_sched #(.NREQ(NREQ), .LATENCY(LATENCY), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_key(req_key), .req_ready(req_ready),
    .core_key(core_key), .core_out(core_out), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag), .inflight(inflight)
`ifdef AES_SCHED_STATS_EN
    , .stat_issued(stat_issued), .stat_stall(stat_stall)
`endif
  );
  always #5 clk = ~clk;
  function automatic logic [127:0] corefn(input logic [127:0] k);
    return {k[100:0], k[127:101]} ^ 128'h9e3779b97f4a7c15f39cc0605cedc834;
  endfunction
  logic [127:0] cm [LATENCY];
  always @(posedge clk) begin
    cm[0] <= corefn(core_key);
    for (int i = 1; i < LATENCY; i++) cm[i] <= cm[i-1];
  end
  assign core_out = cm[LATENCY-1];
  typedef struct { logic [127:0] d; int tag; int t; } ent_t;
  ent_t q[$];
  int mptr = 0, minf = 0, cyc = 0, cmps = 0, errs = 0;
  function automatic logic [NREQ-1:0] exp_ready();
    if (rst || minf >= DEPTH) return '0;
    for (int k = 0; k < NREQ; k++)
      if (req_valid[(mptr + k) % NREQ]) return NREQ'(1) << ((mptr + k) % NREQ);
    return '0;
  endfunction
  function automatic logic exp_valid();
    return q.size() > 0 && q[0].t <= cyc;
  endfunction
  logic [NREQ-1:0] ma;
  logic mp;
  always @(posedge clk) begin
    ma = exp_ready() & req_valid;
    mp = exp_valid() & out_ready;
    if (rst) begin
      mptr = 0;
      minf = 0;
      q.delete();
`ifdef AES_SCHED_STATS_EN
      foreach (m_iss[i]) m_iss[i] = 0;
      m_stall = 0;
`endif
    end else begin
`ifdef AES_SCHED_STATS_EN
      if (|req_valid && minf >= DEPTH) m_stall++;
`endif
      if (mp) void'(q.pop_front());
      for (int i = 0; i < NREQ; i++)
        if (ma[i]) begin
          q.push_back('{d: corefn(req_key[128*i +: 128]), tag: i, t: cyc + LATENCY + 2});
          mptr = (i + 1) % NREQ;
`ifdef AES_SCHED_STATS_EN
          m_iss[i]++;
`endif
        end
      minf += $countones(ma) - int'(mp);
    end
    cyc++;
  end
  task automatic rand_keys();
    for (int i = 0; i < NREQ; i++) req_key[128*i +: 128] = {$urandom, $urandom, $urandom, $urandom};
  endtask
  task automatic test_reset();
    rst = 1;
    req_valid = '1;
    out_ready = 0;
    repeat (3) @(negedge clk);
    cmps++; if (req_ready !== '0) begin errs++; $display("FAIL reset_ready got=%b want=0", req_ready); end
    cmps++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    cmps++; if (out_data !== '0) begin errs++; $display("FAIL reset_out_data got=%h want=0", out_data); end
    cmps++; if (out_tag !== '0) begin errs++; $display("FAIL reset_out_tag got=%0d want=0", out_tag); end
    cmps++; if (inflight !== '0) begin errs++; $display("FAIL reset_inflight got=%0d want=0", inflight); end
    cmps++; if (core_key !== '0) begin errs++; $display("FAIL reset_core_key got=%h want=0", core_key); end
    rst = 0;
    req_valid = '0;
  endtask
  task automatic test_single();
    int n = 0;
    @(negedge clk);
    req_key = '0;
    req_valid = 4'b0001;
    #1;
    cmps++; if (req_ready !== 4'b0001) begin errs++; $display("FAIL single_ready got=%b want=0001", req_ready); end
    while (n < 200) begin
      @(negedge clk);
      n++;
      req_valid = '0;
      if (out_valid) break;
    end
    cmps++; if (n != LATENCY + 2) begin errs++; $display("FAIL single_latency got=%0d want=%0d", n, LATENCY + 2); end
    cmps++; if (out_tag !== 0) begin errs++; $display("FAIL single_tag got=%0d want=0", out_tag); end
    cmps++; if (out_data !== corefn('0)) begin errs++; $display("FAIL single_data got=%h want=%h", out_data, corefn('0)); end
    cmps++; if (inflight !== 1) begin errs++; $display("FAIL single_inflight got=%0d want=1", inflight); end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    cmps++; if (out_valid !== 1'b0) begin errs++; $display("FAIL single_popped got=%b want=0", out_valid); end
    cmps++; if (inflight !== 0) begin errs++; $display("FAIL single_inflight_after got=%0d want=0", inflight); end
  endtask
  task automatic test_traffic(input int n, input int pv, input int pr);
    repeat (n) begin
      @(negedge clk);
      cmps++; if (req_ready !== exp_ready()) begin errs++; $display("FAIL traffic_ready cyc=%0d got=%b want=%b", cyc, req_ready, exp_ready()); end
      cmps++; if (out_valid !== exp_valid()) begin errs++; $display("FAIL traffic_valid cyc=%0d got=%b want=%b", cyc, out_valid, exp_valid()); end
      cmps++; if (int'(inflight) != minf) begin errs++; $display("FAIL traffic_inflight cyc=%0d got=%0d want=%0d", cyc, inflight, minf); end
      if (exp_valid()) begin
        cmps++; if (out_data !== q[0].d || int'(out_tag) != q[0].tag) begin
          errs++; $display("FAIL traffic_head cyc=%0d got=%h/%0d want=%h/%0d", cyc, out_data, out_tag, q[0].d, q[0].tag);
        end
      end
      for (int i = 0; i < NREQ; i++) req_valid[i] = $urandom_range(99) < pv;
      rand_keys();
      out_ready = $urandom_range(99) < pr;
    end
  endtask
  task automatic test_backpressure();
    int cnt = 0;
    out_ready = 0;
    req_valid = '1;
    repeat (DEPTH + 20) begin
      rand_keys();
      #1;
      if (req_ready !== '0) cnt++;
      @(negedge clk);
    end
    repeat (40) @(negedge clk);
    cmps++; if (cnt != DEPTH) begin errs++; $display("FAIL bp_accepts got=%0d want=%0d", cnt, DEPTH); end
    cmps++; if (inflight !== DEPTH) begin errs++; $display("FAIL bp_inflight got=%0d want=%0d", inflight, DEPTH); end
    cmps++; if (req_ready !== '0) begin errs++; $display("FAIL bp_ready got=%b want=0", req_ready); end
    cmps++; if (out_valid !== 1'b1) begin errs++; $display("FAIL bp_out_valid got=%b want=1", out_valid); end
    out_ready = 1;
    #1;
    cmps++; if (req_ready !== '0) begin errs++; $display("FAIL bp_pop_ready got=%b want=0", req_ready); end
    @(negedge clk);
    out_ready = 0;
    #1;
    cmps++; if (inflight !== DEPTH - 1) begin errs++; $display("FAIL bp_after_pop got=%0d want=%0d", inflight, DEPTH - 1); end
    cmps++; if (req_ready !== exp_ready() || req_ready === '0) begin errs++; $display("FAIL bp_reaccept got=%b want=%b", req_ready, exp_ready()); end
    @(negedge clk);
    cmps++; if (inflight !== DEPTH) begin errs++; $display("FAIL bp_refill got=%0d want=%0d", inflight, DEPTH); end
    cmps++; if (req_ready !== '0) begin errs++; $display("FAIL bp_refill_ready got=%b want=0", req_ready); end
    req_valid = '0;
  endtask
  task automatic test_reset_mid();
    int n = 0, extra = 0;
    logic [127:0] k;
    req_valid = '1;
    repeat (10) begin
      rand_keys();
      @(negedge clk);
    end
    req_valid = '0;
    repeat (10) @(negedge clk);
    rst = 1;
    req_valid = 4'b0100;
    rand_keys();
    k = req_key[256 +: 128];
    @(negedge clk);
    rst = 0;
    #1;
    cmps++; if (req_ready !== 4'b0100) begin errs++; $display("FAIL rstmid_first_accept got=%b want=0100", req_ready); end
    while (n < 200) begin
      @(negedge clk);
      n++;
      req_valid = '0;
      if (out_valid) break;
    end
    cmps++; if (n != LATENCY + 2) begin errs++; $display("FAIL rstmid_latency got=%0d want=%0d", n, LATENCY + 2); end
    cmps++; if (out_tag !== 2 || out_data !== corefn(k)) begin errs++; $display("FAIL rstmid_head got=%h/%0d want=%h/2", out_data, out_tag, corefn(k)); end
    out_ready = 1;
    @(negedge clk);
    repeat (60) begin
      if (out_valid) extra++;
      @(negedge clk);
    end
    out_ready = 0;
    cmps++; if (extra != 0) begin errs++; $display("FAIL rstmid_extra got=%0d want=0", extra); end
    cmps++; if (inflight !== 0) begin errs++; $display("FAIL rstmid_inflight got=%0d want=0", inflight); end
  endtask
`ifdef AES_SCHED_STATS_EN
  task automatic test_stats();
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      cmps++; if (int'(stat_issued[32*i +: 32]) != m_iss[i]) begin errs++; $display("FAIL stat_issued%0d got=%0d want=%0d", i, stat_issued[32*i +: 32], m_iss[i]); end
    end
    cmps++; if (int'(stat_stall) != m_stall) begin errs++; $display("FAIL stat_stall got=%0d want=%0d", stat_stall, m_stall); end
    rst = 1;
    @(negedge clk);
    rst = 0;
    cmps++; if (stat_issued !== '0 || stat_stall !== '0) begin errs++; $display("FAIL stat_reset got=%h/%0d want=0/0", stat_issued, stat_stall); end
  endtask
`endif
  initial begin
    test_reset();
    test_single();
    test_traffic(150, 100, 100);
    test_traffic(600, 60, 70);
    test_traffic(200, 0, 100);
    test_backpressure();
    test_traffic(200, 0, 100);
    test_reset_mid();
    test_traffic(300, 50, 50);
`ifdef AES_SCHED_STATS_EN
    test_traffic(200, 100, 5);
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end
endmodule
